// File: rtl/seq_divider_pkg.sv
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared constants and state encoding for the sequential
//                divider. The default width is also used by the multiplier
//                array in the same arithmetic datapath.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package seq_divider_pkg;

  // Default operand width shared with the multiplier array.
  localparam int DEFAULT_N = 8;

  // Controller state encoding.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Iteration counter width. It must hold N-1, and it must be at least 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage : seq_divider_pkg

`default_nettype wire

// File: rtl/seq_divider_if.sv
// ============================================================================
//  Module      : seq_divider_if
//  Description : Request/result bundle for the sequential divider.
//                The master drives the request. The slave returns the results.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_divider_if #(
  parameter int N = seq_divider_pkg::DEFAULT_N
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         ready;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );

endinterface : seq_divider_if

`default_nettype wire

// File: rtl/seq_divider_sub_row.sv
// ============================================================================
//  Module      : nbit_sub_row
//  Description : Combinational W-bit ripple subtractor. It is built from
//                one-bit full-subtract cells and has the same structure as an
//                adder row of the multiplier array.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module nbit_sub_row #(
  parameter int W = 9
) (
  input  wire logic [W-1:0] minuend_i,
  input  wire logic [W-1:0] subtrahend_i,
  output logic      [W-1:0] diff_o,
  output logic              borrow_o
);

  // borrow chain: w_brw[i] is the borrow into cell i.
  logic [W:0] w_brw;

  assign w_brw[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_cell
    logic w_a;
    logic w_b;

    assign w_a         = minuend_i[i];
    assign w_b         = subtrahend_i[i];
    assign diff_o[i]   = w_a ^ w_b ^ w_brw[i];
    assign w_brw[i+1]  = (~w_a & w_b) | (~(w_a ^ w_b) & w_brw[i]);
  end

  // A borrow out of the top cell means minuend < subtrahend.
  assign borrow_o = w_brw[W];

endmodule : nbit_sub_row

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential unsigned N-bit restoring divider. It produces one
//                quotient bit per clock by shift-and-trial-subtract, and it
//                reuses a single subtract row for every iteration.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  wire logic   clk,
  input  wire logic   rst,
  seq_divider_if.slave bus
);

  localparam int CW = cnt_width(N);

  state_t          state_q,  state_d;
  logic [N-1:0]    q_q,      q_d;      // dividend shift reg / quotient build
  logic [N:0]      r_q,      r_d;      // partial remainder
  logic [N-1:0]    d_q,      d_d;      // captured divisor
  logic [CW-1:0]   cnt_q,    cnt_d;
  logic [N-1:0]    quo_q,    quo_d;
  logic [N-1:0]    rem_q,    rem_d;
  logic            dbz_q,    dbz_d;
  // A divide-by-zero spends one silent cycle in DONE. This places its result
  // on the edge after acceptance.
  logic            zpend_q,  zpend_d;

  logic [N:0]      w_trial;
  logic [N:0]      w_diff;
  logic            w_borrow;
  logic [N:0]      w_r_next;
  logic [N-1:0]    w_q_next;
  logic            w_r_msb_unused;

  // Trial value: shift the next dividend bit into the partial remainder.
  assign w_trial = {r_q[N-1:0], q_q[N-1]};

  nbit_sub_row #(
    .W (N + 1)
  ) u_sub_row (
    .minuend_i    (w_trial),
    .subtrahend_i ({1'b0, d_q}),
    .diff_o       (w_diff),
    .borrow_o     (w_borrow)
  );

  // The restoring step keeps the trial value when the subtract borrows.
  assign w_r_next = w_borrow ? w_trial : w_diff;
  assign w_q_next = {q_q[N-2:0], ~w_borrow};

  // The top bit of R is always zero at the end of an iteration, because
  // R < D < 2^N. The shift therefore drops it.
  assign w_r_msb_unused = r_q[N];

  // Next-state and datapath update for each controller state.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    zpend_d = zpend_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          q_d = bus.dividend;
          if (bus.divisor != '0) begin
            state_d = ST_RUN;
            d_d     = bus.divisor;
            r_d     = '0;
            cnt_d   = CW'(N - 1);
          end else begin
            state_d = ST_DONE;
            zpend_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        q_d = w_q_next;
        r_d = w_r_next;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          quo_d   = w_q_next;
          rem_d   = w_r_next[N-1:0];
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      ST_DONE: begin
        if (zpend_q) begin
          // The divisor was zero. Publish the saturated quotient and keep the
          // dividend as the remainder.
          zpend_d = 1'b0;
          quo_d   = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers. rst overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      zpend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      zpend_q <= zpend_d;
    end
  end

  assign bus.ready       = (state_q == ST_IDLE);
  assign bus.done        = (state_q == ST_DONE) && !zpend_q;
  assign bus.quotient    = quo_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule : seq_divider

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider, N = 8.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_divider_if #(.N(N)) bus ();

  seq_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference results from plain integer division.
  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? (1 << N) - 1 : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Issue one division. Check the latency, the held outputs while busy, and
  // the results. Afterwards check the single-cycle pulse and the return to
  // ready.
  task automatic run_div(input int a, input int b);
    int eq, er, elat, lat, held;
    eq   = ref_q(a, b);
    er   = ref_r(a, b);
    elat = (b == 0) ? 1 : N;
    held = int'(bus.quotient);
    check("ready_before", int'(bus.ready), 1);
    bus.start    = 1'b1;
    bus.dividend = a[N-1:0];
    bus.divisor  = b[N-1:0];
    step();
    bus.start    = 1'b0;
    bus.dividend = N'($urandom);
    bus.divisor  = N'($urandom);
    lat = 0;
    while (!bus.done && lat < 40) begin
      check("held_quotient", int'(bus.quotient), held);
      check("busy_not_ready", int'(bus.ready), 0);
      step();
      lat++;
    end
    check("latency", lat, elat);
    check("quotient", int'(bus.quotient), eq);
    check("remainder", int'(bus.remainder), er);
    check("div_by_zero", int'(bus.div_by_zero), (b == 0) ? 1 : 0);
    step();
    check("done_single", int'(bus.done), 0);
    check("ready_after", int'(bus.ready), 1);
    check("quotient_held", int'(bus.quotient), eq);
  endtask

  initial begin
    int dones, lat;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    // Reset held for two cycles.
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_ready", int'(bus.ready), 1);
    check("rst_done", int'(bus.done), 0);
    check("rst_quotient", int'(bus.quotient), 0);
    check("rst_remainder", int'(bus.remainder), 0);
    check("rst_dbz", int'(bus.div_by_zero), 0);

    // Directed operands, including the corner cases.
    run_div(100, 7);
    run_div(255, 1);
    run_div(5, 9);
    run_div(255, 255);
    run_div(200, 0);
    run_div(9, 2);

    // Hold start with new operands during a run and toggle them mid-run.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    step();
    bus.dividend = 8'd50;
    bus.divisor  = 8'd3;
    dones = 0;
    lat   = 0;
    while (!bus.done && lat < 40) begin
      if (lat == 3) begin
        bus.dividend = 8'd17;
        bus.divisor  = 8'd0;
      end
      if (lat == 5) begin
        bus.dividend = 8'd50;
        bus.divisor  = 8'd3;
      end
      step();
      lat++;
    end
    if (bus.done) dones++;
    check("held_start_latency", lat, N);
    check("held_start_q", int'(bus.quotient), 14);
    check("held_start_r", int'(bus.remainder), 2);
    step();
    check("held_start_ready", int'(bus.ready), 1);
    check("held_start_one_done", dones + int'(bus.done), 1);
    // start is still high, so 50/3 is accepted on this edge.
    step();
    bus.start = 1'b0;
    check("second_accepted", int'(bus.ready), 0);
    lat = 0;
    while (!bus.done && lat < 40) begin
      step();
      lat++;
    end
    check("second_latency", lat, N);
    check("second_q", int'(bus.quotient), 16);
    check("second_r", int'(bus.remainder), 2);
    step();

    // Reset on the fourth RUN cycle aborts the operation.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_ready", int'(bus.ready), 1);
    check("abort_done", int'(bus.done), 0);
    check("abort_quotient", int'(bus.quotient), 0);
    check("abort_remainder", int'(bus.remainder), 0);
    check("abort_dbz", int'(bus.div_by_zero), 0);
    run_div(9, 2);

    // Random operands, with a zero divisor roughly one time in eight.
    for (int i = 0; i < 24; i++) begin
      int a, b;
      a = int'($urandom_range(255, 0));
      b = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(255, 1));
      run_div(a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seq_divider

`default_nettype wire

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Sequential unsigned N-bit restoring divider; the inverse of the distributed-arithmetic multiplier array.
- The multiplier array builds a product by adding shifted partial products, one row per bit.
- This block recovers quotient and remainder by shift-and-trial-subtract, one quotient bit per clock, reusing a single subtract row across iterations.
- Sits beside the multiplier array in the lab arithmetic datapath.

Parameters:
- N, 8, operand width in bits for dividend, divisor, quotient and remainder (N >= 2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a division; sampled only while ready=1.
- dividend  input  N  unsigned dividend; captured on the accepted start.
- divisor  input  N  unsigned divisor; captured on the accepted start.
- ready  output  1  high only in IDLE; block accepts start.
- done  output  1  single-cycle pulse: results are valid.
- quotient  output  N  unsigned quotient; held until the next accepted start.
- remainder  output  N  unsigned remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor was 0; held like quotient.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- rst wins over every other input in the same cycle.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on start=1 and divisor!=0.
  - Capture dividend into shift register Q and divisor into D.
  - Clear partial remainder R (N+1 bits).
  - Set counter = N-1.
  - Clear div_by_zero.
- IDLE -> DONE: on start=1 and divisor==0.
  - quotient = all ones, remainder = dividend, div_by_zero=1.
  - No RUN cycles.
- RUN, one iteration per cycle:
  - T = {R[N-1:0], Q[N-1]}.
  - diff = T - {1'b0, D}, computed by the subtract row.
  - If no borrow: R <= diff and new quotient bit = 1.
  - Otherwise: R <= T and new quotient bit = 0.
  - Q <= {Q[N-2:0], qbit}.
  - If counter==0, go to DONE; else decrement the counter.
- DONE, one cycle only:
  - done=1, quotient=Q, remainder=R[N-1:0].
  - Unconditionally go to IDLE.
- Latency:
  - Start accepted at edge k -> done high in the cycle after edge k+N (N RUN cycles).
  - Divide-by-zero: done high in the cycle after edge k+1.
  - Next start accepted one cycle after done (back in IDLE).
- start while ready=0 (RUN or DONE) is ignored. No queuing, no error.
- dividend and divisor changes after capture have no effect.
- rst mid-RUN or in DONE:
  - Aborts the operation; no done pulse is issued for it.
  - Outputs return to reset values; ready=1 in the cycle after the reset edge.
- Width rules:
  - R is N+1 bits so the trial subtract never overflows.
  - The stored remainder is always < divisor, hence fits in N bits.
- Results: quotient/remainder/div_by_zero change only on the DONE transition or on rst. They are stable between done pulses.

Decomposition:
- Shared package: state encoding constants (IDLE, RUN, DONE) and the default width constant N, shared with the multiplier array.
- Sub-module nbit_sub_row: combinational (N+1)-bit ripple subtract built from one-bit full-subtract cells.
  - Inputs: minuend, subtrahend.
  - Outputs: difference, borrow out.
  - Mirrors the multiplier's adder-row structure.
- Top-level seq_divider holds the FSM, counter, and the Q, R and D registers.

Test Plan:
- N=8, rst high for 2 cycles -> ready=1, done=0, quotient=0, remainder=0, div_by_zero=0.
- start with dividend=100, divisor=7 -> done pulses once, 8 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; ready=1 the following cycle.
- Corner operands, each started in a separate run:
  - 255/1 -> q=255, r=0.
  - 5/9 -> q=0, r=5.
  - 255/255 -> q=1, r=0.
- 200/0 -> done in the cycle after the edge following acceptance; quotient=255, remainder=200, div_by_zero=1.
- start=1 with 50/3 held during RUN of 100/7, inputs toggled mid-run -> single done; result 14 r 2; 50/3 accepted only after ready returns.
- rst asserted on the 4th RUN cycle of 100/7 -> no done pulse; outputs 0 and ready=1 next cycle; an immediate new start 9/2 -> q=4, r=1.
